// File: rtl/sp_ram_bridge_pkg.sv
// sp_ram_bridge shared types: response entry and buffer depth.
// Optional SP_RAM_BRIDGE_ERR_EN adds an out-of-range error flag.
package sp_ram_bridge_pkg;

  localparam int SP_RAM_BRIDGE_RSP_DEPTH = 2;
  localparam int SP_RAM_BRIDGE_CNT_W =
    $clog2(SP_RAM_BRIDGE_RSP_DEPTH + 1);
  localparam int SP_RAM_BRIDGE_DW = 32;

  typedef struct packed {
    logic [SP_RAM_BRIDGE_DW-1:0] rdata;
    logic                        err;
  } rsp_t;

endpackage

// File: rtl/sp_ram_bridge_rsp_buf.sv
// sp_ram_bridge_rsp_buf: two-entry in-order response buffer.
// Head register feeds the output; skid holds the second entry.
module sp_ram_bridge_rsp_buf
  import sp_ram_bridge_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  rsp_t                           push_data,
  input  logic                           pop,
  output rsp_t                           head,
  output logic                           head_valid,
  output logic [SP_RAM_BRIDGE_CNT_W-1:0] count
);

  rsp_t skid_q;
  logic skid_v_q;

  assign count = SP_RAM_BRIDGE_CNT_W'(head_valid)
               + SP_RAM_BRIDGE_CNT_W'(skid_v_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      head_valid <= 1'b0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (skid_v_q) begin
            head   <= skid_q;
            skid_q <= push_data;
          end else begin
            head <= push_data;
          end
        end
        push && !pop: begin
          if (!head_valid) begin
            head       <= push_data;
            head_valid <= 1'b1;
          end else begin
            skid_q   <= push_data;
            skid_v_q <= 1'b1;
          end
        end
        pop && !push: begin
          if (skid_v_q) begin
            head     <= skid_q;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
          end else begin
            head       <= '0;
            head_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_bridge.sv
// sp_ram_bridge: req/gnt/rvalid front end for a byte-enabled SRAM.
// Define SP_RAM_BRIDGE_ERR_EN for out-of-range error responses.
module sp_ram_bridge
  import sp_ram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = SP_RAM_BRIDGE_DW,
  parameter int NUM_WORDS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    rready_i,
`ifdef SP_RAM_BRIDGE_ERR_EN
  output logic                    err_o,
`endif
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int CW = SP_RAM_BRIDGE_CNT_W;

  logic          p_q;
  logic          p_we_q;
  logic          p_err_q;
  logic          accept;
  logic          pop;
  logic          oob;
  logic [CW-1:0] held;
  logic [CW-1:0] cnt;
  logic          head_valid;
  rsp_t          head;
  rsp_t          cap;

  // Occupancy counts the in-flight SRAM access as well as held entries.
  assign cnt    = held + CW'(p_q);
  assign pop    = head_valid && rready_i;
  assign accept = req_i && !rst &&
                  (cnt < CW'(SP_RAM_BRIDGE_RSP_DEPTH) || pop);
  assign gnt_o  = accept;

`ifdef SP_RAM_BRIDGE_ERR_EN
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(NUM_WORDS);
  assign oob   = {1'b0, addr_i} >= LIMIT;
  assign err_o = head.err;
`else
  logic unused_err;
  assign oob        = 1'b0;
  assign unused_err = head.err;
`endif

  assign ram_en_o    = accept && !oob;
  assign ram_we_o    = ram_en_o && we_i;
  assign ram_addr_o  = ram_en_o ? addr_i  : '0;
  assign ram_be_o    = ram_en_o ? be_i    : '0;
  assign ram_wdata_o = ram_en_o ? wdata_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= 1'b0;
      p_we_q  <= 1'b0;
      p_err_q <= 1'b0;
    end else begin
      p_q     <= accept;
      p_we_q  <= accept && we_i;
      p_err_q <= accept && oob;
    end
  end

  always_comb begin
    cap       = '0;
    cap.err   = p_err_q;
    cap.rdata = (p_we_q || p_err_q) ? '0 : ram_rdata_i;
  end

  sp_ram_bridge_rsp_buf u_rsp_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (p_q),
    .push_data  (cap),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (held)
  );

  assign rvalid_o = head_valid;
  assign rdata_o  = head.rdata;

endmodule

// File: tb/tb_sp_ram_bridge.sv
// tb_sp_ram_bridge: scoreboard bench with SRAM and byte-memory model.
// Build with SP_RAM_BRIDGE_ERR_EN to also cover error responses.
module tb_sp_ram_bridge;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int NW = 256;
`ifdef SP_RAM_BRIDGE_ERR_EN
  localparam int AW = 9;
`else
  localparam int AW = 8;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            gc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i, gnt_o, we_i;
  logic [AW-1:0] addr_i;
  logic [BW-1:0] be_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o, rready_i;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i = '0;

  sp_ram_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .rready_i    (rready_i),
`ifdef SP_RAM_BRIDGE_ERR_EN
    .err_o       (err_o),
`endif
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

`ifndef SP_RAM_BRIDGE_ERR_EN
  assign err_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // SRAM: registered read, byte-enabled write
  logic [7:0] mem [NW];
  always @(posedge clk) begin
    if (ram_en_o) begin
      for (int i = 0; i < BW; i++) begin
        if (ram_we_o && ram_be_o[i])
          mem[int'(ram_addr_o)+i] <= ram_wdata_o[8*i+:8];
        if (!ram_we_o)
          ram_rdata_i[8*i+:8] <= mem[int'(ram_addr_o)+i];
      end
    end
  end

  // Reference: flat byte memory updated at grant time
  logic [7:0] ref_mem [NW];
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst && gnt_o) begin
      a    = int'(addr_i);
      e.gc = cyc;
      e.e  = 1'b0;
      e.d  = '0;
      if (a >= NW) e.e = 1'b1;
      else if (we_i) begin
        for (int i = 0; i < BW; i++)
          if (be_i[i]) ref_mem[a+i] = wdata_i[8*i+:8];
      end else begin
        for (int i = 0; i < BW; i++)
          e.d[8*i+:8] = ref_mem[a+i];
      end
      q.push_back(e);
    end
  end

  int            pop_n = 0, first_pop = 0, last_pop = 0;
  logic          held = 1'b0;
  logic [DW-1:0] held_val;

  always @(negedge clk) begin
    exp_t e;
    if (rst) held = 1'b0;
    else begin
      if (held && rvalid_o)
        chk("rdata_stable", rdata_o, held_val);
      held     = rvalid_o && !rready_i;
      held_val = rdata_o;
      if (rvalid_o && rready_i) begin
        pop_n++;
        if (pop_n == 1) first_pop = cyc;
        last_pop = cyc;
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got rdata %0h, none expected",
                   rdata_o);
        end else begin
          e = q.pop_front();
          chk("rdata", rdata_o, e.d);
`ifdef SP_RAM_BRIDGE_ERR_EN
          chk("err", err_o, e.e);
`endif
          chk("latency_ge2", 64'((cyc - e.gc) >= 2), 1);
        end
      end
    end
  end

  logic tog = 1'b0;
  always @(posedge clk) if (tog) begin #1 rready_i = ~rready_i; end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [DW-1:0] d,
                       output int gc);
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    gc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt_o) begin gc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    if (gc < 0) begin
      n_checks++;
      $display("FAIL grant_timeout: got no gnt_o, required one");
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
`ifdef SP_RAM_BRIDGE_ERR_EN
    if ($urandom % 8 == 0)
      return AW'(NW + 4 * $urandom_range(0, 63));
`endif
    return AW'(4 * $urandom_range(0, NW/4 - 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, gcount, n;
    logic gg;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 16; i < 20; i++) begin
      mem[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    rst = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 'h10;
    be_i = '1; wdata_i = 32'hDEADBEEF; rready_i = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ram_en", ram_en_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_be", ram_be_o, 0);
    chk("rst_ram_wdata", ram_wdata_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_i = 1'b0;

    // byte-enabled write then read-back, with exact latency
    issue(1'b1, 'h10, 4'b0101, 32'hAABBCCDD, g);
    idle(4);
    issue(1'b0, 'h10, 4'hF, '0, g);
    @(negedge clk);
    chk("lat_n1_rvalid", rvalid_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_n2_rvalid", rvalid_o, 1);
    chk("be_merge", rdata_o, 32'h00BB00DD);
    idle(3);

    // back-to-back reads
    pop_n = 0; gcount = 0;
    for (int i = 0; i < 8; i++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = AW'(4 * i);
      @(negedge clk); gcount += int'(gnt_o);
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    idle(6);
    chk("b2b_grants", gcount, 8);
    chk("b2b_rsp_count", pop_n, 8);
    chk("b2b_rsp_contig", last_pop - first_pop, 7);

    // back-pressure: exactly two accepted
    rready_i = 1'b0; gcount = 0;
    for (int i = 0; i < 8; i++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = AW'(32 + 4 * i);
      @(negedge clk); gcount += int'(gnt_o);
      @(posedge clk); #1;
    end
    chk("stall_grants", gcount, 2);
    rready_i = 1'b1;
    @(negedge clk);
    chk("gnt_on_pop", gnt_o, 1);
    chk("rvalid_on_pop", rvalid_o, 1);
    @(posedge clk); #1;
    req_i = 1'b0;
    idle(5);

    // read/write/read with toggling rready
    tog = 1'b1;
    issue(1'b0, 'h20, 4'hF, '0, g);
    issue(1'b1, 'h20, 4'($urandom), $urandom, g);
    issue(1'b0, 'h20, 4'hF, '0, g);
    idle(8);
    tog = 1'b0; rready_i = 1'b1;
    idle(4);

    // reset with two held responses
    rready_i = 1'b0;
    issue(1'b0, 'h24, 4'hF, '0, g);
    issue(1'b0, 'h28, 4'hF, '0, g);
    idle(3);
    @(negedge clk);
    chk("rst_pre_rvalid", rvalid_o, 1);
    @(posedge clk); #1;
    rst = 1'b1; q.delete();
    @(posedge clk); #1;
    rst = 1'b0; rready_i = 1'b1;
    @(negedge clk);
    chk("rst_rvalid_clear", rvalid_o, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk); n += int'(rvalid_o);
      @(posedge clk); #1;
    end
    chk("rst_no_late", n, 0);

`ifdef SP_RAM_BRIDGE_ERR_EN
    issue(1'b0, 'h0FC, 4'hF, '0, g);
    req_i = 1'b1; we_i = 1'b0; addr_i = 'h100;
    @(negedge clk);
    chk("oob_gnt", gnt_o, 1);
    chk("oob_ram_en", ram_en_o, 0);
    @(posedge clk); #1;
    req_i = 1'b0;
    idle(4);
`endif

    // randomized traffic, requests held until granted
    gg = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rready_i = ($urandom % 4) != 0;
      if (!req_i || gg) begin
        if ($urandom % 10 < 7) begin
          req_i = 1'b1; we_i = 1'($urandom);
          addr_i = rand_addr();
          be_i = 4'($urandom); wdata_i = $urandom;
        end else req_i = 1'b0;
      end
      @(negedge clk); gg = gnt_o;
      @(posedge clk); #1;
    end
    req_i = 1'b0; rready_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0) break;
      idle(1);
    end
    idle(2);
    chk("drain_empty", q.size(), 0);
    chk("drain_rvalid", rvalid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_bridge.md
# sp_ram_bridge

Request-side front end for the single-port byte-enabled SRAM. Converts the core/interconnect req/gnt/rvalid data protocol, with consumer back-pressure via `rready_i`, into the SRAM's en/we/be/addr/wdata strobe interface. It captures the SRAM's one-cycle-latency read data into an in-order two-entry response buffer. Sits directly upstream of the SRAM instance in the data-memory subsystem.

## Interface
- `ADDR_WIDTH`, 8: byte address width; passed unchanged to the SRAM.
- `DATA_WIDTH`, 32: data width, multiple of 8.
- `NUM_WORDS`, 256: SRAM capacity in bytes; passed unchanged to the SRAM.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input 1: request valid.
- `gnt_o` output 1: request accepted this cycle.
- `addr_i` input ADDR_WIDTH: byte address.
- `we_i` input 1: 1 = write, 0 = read.
- `be_i` input DATA_WIDTH/8: byte enables (writes only).
- `wdata_i` input DATA_WIDTH: write data.
- `rvalid_o` output 1: response valid.
- `rdata_o` output DATA_WIDTH: read data; 0 for write responses.
- `rready_i` input 1: consumer accepts the response.
- `err_o` output 1: response error flag (only with `SP_RAM_BRIDGE_ERR_EN`).
- `ram_en_o`, `ram_we_o` output 1: SRAM strobes.
- `ram_addr_o` output ADDR_WIDTH, `ram_be_o` output DATA_WIDTH/8, `ram_wdata_o` output DATA_WIDTH: SRAM request fields.
- `ram_rdata_i` input DATA_WIDTH: SRAM registered read data.

## Operation
- Every accepted request, read or write, produces exactly one response. Responses are returned in order.
- Occupancy `cnt` = pending SRAM access (P) + held responses (max 2). Occupancy states are EMPTY (0), ONE (1) and TWO (2).
- `pop` = `rvalid_o && rready_i`. `gnt_o = req_i && !rst && (cnt < 2 || pop)`. The `rready_i` to `gnt_o` path is combinational by design.
- On accept: `ram_en_o = 1`, and `ram_we_o/addr/be/wdata` are driven combinationally from the inputs in the same cycle. P is set for the next cycle, recording `we`.
- When `ram_en_o = 0`, the SRAM fields are held at 0.
- Next cycle (P set): `ram_rdata_i` is captured for reads and 0 is captured for writes. It goes into the response-buffer tail; P clears unless a new request is accepted.
- State transitions: accept without pop → `cnt` + 1; pop without accept → `cnt` − 1; both or neither → unchanged.
- `cnt` never exceeds 2. A capture never overwrites a held response.
- `rvalid_o` and `rdata_o` are driven from the buffer head register, so `rdata_o` is stable while `rvalid_o && !rready_i`.

## Timing
- Reset values: `gnt_o` 0, `rvalid_o` 0, `rdata_o` 0, `err_o` 0, `ram_*` 0, `cnt` 0.
- Read latency: accept in cycle N → `rvalid_o` in cycle N+2 at the earliest, whether the buffer is empty or being popped.
- Throughput: 1 request/cycle sustained while `rready_i` stays high.
- With `rready_i` held low, exactly 2 requests are accepted, then `gnt_o` stays 0 until a pop.
- A pop and an accept in the same cycle are both honoured.
- Reset mid-operation: pending and held responses are discarded, and no late `rvalid_o` follows reset release.
- A write issued in cycle N is visible to a read accepted in cycle N+1 or later.

## Configuration
- `SP_RAM_BRIDGE_ERR_EN` defined:
  - `err_o` is present.
  - A request with `addr_i >= NUM_WORDS` is granted normally, but `ram_en_o` stays 0.
  - Its response carries `err_o = 1` and `rdata_o = 0`, with the same latency and ordering as a normal response.
  - `err_o` is valid only with `rvalid_o`.
- Undefined:
  - No `err_o` port.
  - All addresses are forwarded to the SRAM unchanged.

## Structure
- Shared package `sp_ram_bridge_pkg` holds:
  - constant `SP_RAM_BRIDGE_RSP_DEPTH = 2`;
  - the response-entry typedef (`rdata`, `err`).
- Sub-module `sp_ram_bridge_rsp_buf`: 2-entry in-order response buffer (head/skid registers, push/pop, occupancy). The top level holds the grant logic, the SRAM drive and P.

## Test plan
- Write `addr 0x10`, `be 4'b0101`, `wdata 0xAABBCCDD` over prior `0x00000000`; then read `0x10` → `rdata_o = 0x00BB00DD`, `rvalid_o` two cycles after the read grant.
- 8 back-to-back reads of preloaded addresses 0x00..0x1C, `rready_i = 1` → 8 grants in 8 consecutive cycles, and 8 in-order responses in consecutive cycles.
- `rready_i = 0`, `req_i` held high → exactly 2 grants, then `gnt_o = 0`. Raise `rready_i` → the held responses drain in order and `gnt_o` reasserts in the same cycle as the first pop.
- Read, write, read to the same address with `rready_i` toggling 1/0 every cycle → responses in order, write response `rdata_o = 0`, `rdata_o` stable while stalled.
- Assert `rst` for 1 cycle with 2 responses held → `rvalid_o = 0` the next cycle, and no response appears afterwards without a new request.
- With `SP_RAM_BRIDGE_ERR_EN`, `NUM_WORDS = 256`, read `addr 0xFC` then `0x100` (`ADDR_WIDTH = 9`) → first `err_o = 0`, second `err_o = 1` with `rdata_o = 0` and `ram_en_o` never high for it.
